instr_decode_stage: RTL and testbench

//  Registered RV32I (+Zihintpause) decode pipeline stage between fetch and execute.

---
 rtl/rv_decode_pkg.sv | 54 +++++
 rtl/rv32i_decode_comb.sv | 142 ++++++++++++++
 rtl/instr_decode_stage.sv | 122 ++++++++++++
 tb/tb_instr_decode_stage.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_decode_pkg.sv
// Shared RV32I decode constants, the decoded-bundle payload type and op-code packing helper.
package rv_decode_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP        = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [6:0] FN7_ZERO = 7'b0000000;
  localparam logic [6:0] FN7_ALT  = 7'b0100000;

  localparam logic [1:0] RD_SEL_ALU = 2'b00;
  localparam logic [1:0] RD_SEL_BUS = 2'b01;
  localparam logic [1:0] RD_SEL_IMM = 2'b10;
  localparam logic [1:0] RD_SEL_PC4 = 2'b11;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam logic [31:0] PAUSE_ENCODING = 32'h0100000F;

  typedef struct packed {
    logic [15:0] op_code;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        imm_rs2_sel;
    logic        alu_sel;
    logic        reg_w;
    logic        data_w;
    logic        data_r;
    logic        is_unsigned;
    logic        branch;
    logic        load_pc;
    logic [1:0]  rd_data_sel;
    logic [1:0]  data_size;
    logic        illegal;
  } decode_t;

  // fn7[6] is zero in every legal encoding, so only fn7[5:0] is carried in the 16-bit op code.
  function automatic logic [15:0] pack_op(input logic [5:0] fn7_lo, input logic [2:0] fn3,
                                          input logic [6:0] opcode);
    return {fn7_lo, fn3, opcode};
  endfunction

endpackage

// File: rtl/rv32i_decode_comb.sv
// Pure combinational RV32I decoder: one instruction word to a decoded bundle, illegal flag and
// PAUSE detect. Illegal encodings yield an all-zero bundle with only illegal set.
module rv32i_decode_comb
  import rv_decode_pkg::*;
(
  input  logic [31:0] instr,
  output decode_t     dec,
  output logic        is_pause
);

  logic [6:0]  opcode;
  logic [2:0]  fn3;
  logic [6:0]  fn7;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] shamt;
  logic        is_shift;
  logic        legal;

  assign opcode   = instr[6:0];
  assign fn3      = instr[14:12];
  assign fn7      = instr[31:25];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign rd       = instr[11:7];
  assign imm_i    = {{20{instr[31]}}, instr[31:20]};
  assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u    = {instr[31:12], 12'b0};
  assign imm_j    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign shamt    = {27'b0, instr[24:20]};
  assign is_shift = (fn3[1:0] == 2'b01);
  assign is_pause = (instr == PAUSE_ENCODING);

  always_comb begin
    dec   = '0;
    legal = 1'b0;
    case (opcode)
      OP_LOAD: begin
        legal           = (fn3[1:0] != 2'b11) && !(fn3[2] && fn3[1]);
        dec.op_code     = pack_op(6'b0, fn3, opcode);
        dec.rs1         = rs1;
        dec.rd          = rd;
        dec.imm         = imm_i;
        dec.imm_rs2_sel = 1'b1;
        dec.reg_w       = 1'b1;
        dec.data_r      = 1'b1;
        dec.is_unsigned = fn3[2];
        dec.rd_data_sel = RD_SEL_BUS;
        dec.data_size   = fn3[1:0];
      end
      OP_STORE: begin
        legal           = !fn3[2] && (fn3[1:0] != 2'b11);
        dec.op_code     = pack_op(6'b0, fn3, opcode);
        dec.rs1         = rs1;
        dec.rs2         = rs2;
        dec.imm         = imm_s;
        dec.imm_rs2_sel = 1'b1;
        dec.data_w      = 1'b1;
        dec.data_size   = fn3[1:0];
      end
      OP_BRANCH: begin
        legal           = (fn3[2:1] != 2'b01);
        dec.op_code     = pack_op(6'b0, fn3, opcode);
        dec.rs1         = rs1;
        dec.rs2         = rs2;
        dec.imm         = imm_b;
        dec.branch      = 1'b1;
        dec.is_unsigned = fn3[1];
      end
      OP_JALR: begin
        legal           = (fn3 == 3'b000);
        dec.op_code     = pack_op(6'b0, fn3, opcode);
        dec.rs1         = rs1;
        dec.rd          = rd;
        dec.imm         = imm_i;
        dec.imm_rs2_sel = 1'b1;
        dec.reg_w       = 1'b1;
        dec.load_pc     = 1'b1;
        dec.rd_data_sel = RD_SEL_PC4;
      end
      OP_JAL: begin
        legal           = 1'b1;
        dec.op_code     = pack_op(6'b0, 3'b000, opcode);
        dec.rd          = rd;
        dec.imm         = imm_j;
        dec.imm_rs2_sel = 1'b1;
        dec.reg_w       = 1'b1;
        dec.load_pc     = 1'b1;
        dec.rd_data_sel = RD_SEL_PC4;
      end
      OP_LUI, OP_AUIPC: begin
        legal           = 1'b1;
        dec.op_code     = pack_op(6'b0, 3'b000, opcode);
        dec.rd          = rd;
        dec.imm         = imm_u;
        dec.imm_rs2_sel = 1'b1;
        dec.reg_w       = 1'b1;
        dec.rd_data_sel = (opcode == OP_LUI) ? RD_SEL_IMM : RD_SEL_ALU;
      end
      OP_IMM: begin
        // Shift-immediates reuse the fn7 field; only SRAI may set the alternate bit.
        legal           = !is_shift || (fn7 == FN7_ZERO) || (fn3[2] && (fn7 == FN7_ALT));
        dec.op_code     = pack_op(is_shift ? fn7[5:0] : 6'b0, fn3, opcode);
        dec.rs1         = rs1;
        dec.rd          = rd;
        dec.imm         = is_shift ? shamt : imm_i;
        dec.imm_rs2_sel = 1'b1;
        dec.alu_sel     = 1'b1;
        dec.reg_w       = 1'b1;
        dec.is_unsigned = (fn3 == 3'b011);
      end
      OP: begin
        legal           = (fn7 == FN7_ZERO) ||
                          ((fn7 == FN7_ALT) && ((fn3 == 3'b000) || (fn3 == 3'b101)));
        dec.op_code     = pack_op(fn7[5:0], fn3, opcode);
        dec.rs1         = rs1;
        dec.rs2         = rs2;
        dec.rd          = rd;
        dec.alu_sel     = 1'b1;
        dec.reg_w       = 1'b1;
        dec.is_unsigned = (fn3 == 3'b011);
      end
      OP_FENCE: begin
        legal       = (fn3 == 3'b000);
        dec.op_code = pack_op(6'b0, fn3, opcode);
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered RV32I decode stage: valid/ready handshake, output bundle register, local PAUSE
// stall counter and redirect flush.
module instr_decode_stage
  import rv_decode_pkg::*;
#(
  parameter int unsigned PC_W         = 32,
  parameter int unsigned PAUSE_CYCLES = 16,
  parameter int unsigned EN_PAUSE     = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [15:0]     out_op_code,
  output logic [4:0]      out_rs1_sel,
  output logic [4:0]      out_rs2_sel,
  output logic [4:0]      out_rd_sel,
  output logic [31:0]     out_imm,
  output logic            out_imm_rs2_sel,
  output logic            out_alu_sel,
  output logic            out_reg_w,
  output logic            out_data_w,
  output logic            out_data_r,
  output logic            out_unsigned,
  output logic            out_branch,
  output logic            out_load_pc,
  output logic [1:0]      out_rd_data_sel,
  output logic [1:0]      out_data_size,
  output logic            out_illegal,
  output logic            pause_busy
);

  localparam int unsigned CNT_W    = $clog2(PAUSE_CYCLES + 1);
  localparam bit          PAUSE_ON = (EN_PAUSE != 0);

  typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_PAUSE} state_t;

  state_t           state;
  logic [CNT_W-1:0] pause_cnt;
  decode_t          dec;
  decode_t          bundle;
  logic             dec_is_pause;
  logic             accept;
  logic             pause_hit;

  rv32i_decode_comb u_decode (
    .instr    (in_instr),
    .dec      (dec),
    .is_pause (dec_is_pause)
  );

  assign in_ready   = !flush && (state != ST_PAUSE) && ((state == ST_EMPTY) || out_ready);
  assign accept     = in_valid && in_ready;
  assign pause_hit  = PAUSE_ON && dec_is_pause;
  assign pause_busy = (state == ST_PAUSE);

  // Handshake FSM, pause countdown and bundle register; flush overrides everything but reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_EMPTY;
      pause_cnt <= '0;
      out_valid <= 1'b0;
      bundle    <= '0;
      out_pc    <= '0;
    end else if (flush) begin
      state     <= ST_EMPTY;
      pause_cnt <= '0;
      out_valid <= 1'b0;
    end else if (accept && pause_hit) begin
      state     <= ST_PAUSE;
      pause_cnt <= CNT_W'(PAUSE_CYCLES);
      out_valid <= 1'b0;
    end else if (accept) begin
      state     <= ST_FULL;
      out_valid <= 1'b1;
      bundle    <= dec;
      out_pc    <= in_pc;
    end else begin
      case (state)
        ST_FULL: begin
          if (out_ready) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
          end
        end
        ST_PAUSE: begin
          if (pause_cnt <= CNT_W'(1)) begin
            state     <= ST_EMPTY;
            pause_cnt <= '0;
          end else begin
            pause_cnt <= pause_cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign out_op_code     = bundle.op_code;
  assign out_rs1_sel     = bundle.rs1;
  assign out_rs2_sel     = bundle.rs2;
  assign out_rd_sel      = bundle.rd;
  assign out_imm         = bundle.imm;
  assign out_imm_rs2_sel = bundle.imm_rs2_sel;
  assign out_alu_sel     = bundle.alu_sel;
  assign out_reg_w       = bundle.reg_w;
  assign out_data_w      = bundle.data_w;
  assign out_data_r      = bundle.data_r;
  assign out_unsigned    = bundle.is_unsigned;
  assign out_branch      = bundle.branch;
  assign out_load_pc     = bundle.load_pc;
  assign out_rd_data_sel = bundle.rd_data_sel;
  assign out_data_size   = bundle.data_size;
  assign out_illegal     = bundle.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage: directed scenarios plus randomized traffic
// against a rule-based decode model and an occupancy/countdown handshake model.
module tb_instr_decode_stage;

  localparam int unsigned PC_W  = 32;
  localparam int unsigned PCYC  = 4;
  localparam logic [31:0] PAUSE = 32'h0100000F;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     in_instr = '0;
  logic [PC_W-1:0] in_pc = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [PC_W-1:0] out_pc;
  logic [15:0]     out_op_code;
  logic [4:0]      out_rs1_sel, out_rs2_sel, out_rd_sel;
  logic [31:0]     out_imm;
  logic            out_imm_rs2_sel, out_alu_sel, out_reg_w, out_data_w, out_data_r;
  logic            out_unsigned, out_branch, out_load_pc, out_illegal, pause_busy;
  logic [1:0]      out_rd_data_sel, out_data_size;

  instr_decode_stage #(.PC_W(PC_W), .PAUSE_CYCLES(PCYC), .EN_PAUSE(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_op_code(out_op_code), .out_rs1_sel(out_rs1_sel),
    .out_rs2_sel(out_rs2_sel), .out_rd_sel(out_rd_sel), .out_imm(out_imm),
    .out_imm_rs2_sel(out_imm_rs2_sel), .out_alu_sel(out_alu_sel), .out_reg_w(out_reg_w),
    .out_data_w(out_data_w), .out_data_r(out_data_r), .out_unsigned(out_unsigned),
    .out_branch(out_branch), .out_load_pc(out_load_pc), .out_rd_data_sel(out_rd_data_sel),
    .out_data_size(out_data_size), .out_illegal(out_illegal), .pause_busy(pause_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] op;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [12:0] ctrl;  // {isel,alu,regw,dw,dr,uns,br,lpc,rdsel[1:0],size[1:0],ill}
  } exp_t;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bit          m_full;
  int          m_pause;
  exp_t        m_bund;
  logic [31:0] m_pc;
  logic [31:0] emit_pc[$];
  int          emit_cyc[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference decode: classify by legality rules and instruction format, then derive fields.
  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t        e;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    byte         fmt;
    bit          legal, shift;
    logic        isel, alu, regw, dw, dr, uns, br, lpc;
    logic [1:0]  rdsel, size;
    opc   = w[6:0];
    f3    = w[14:12];
    f7    = w[31:25];
    shift = (opc == 7'h13) && (f3 == 3'd1 || f3 == 3'd5);
    legal = 1'b1;
    fmt   = "N";
    case (opc)
      7'h03: begin legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}; fmt = "I"; end
      7'h13: begin legal = !shift || f7 == 7'h00 || (f3 == 3'd5 && f7 == 7'h20); fmt = "I"; end
      7'h17, 7'h37: fmt = "U";
      7'h23: begin legal = (f3 <= 3'd2); fmt = "S"; end
      7'h33: begin legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)); fmt = "R"; end
      7'h63: begin legal = !(f3 inside {3'd2, 3'd3}); fmt = "B"; end
      7'h67: begin legal = (f3 == 3'd0); fmt = "I"; end
      7'h6F: fmt = "J";
      7'h0F: legal = (f3 == 3'd0);
      default: legal = 1'b0;
    endcase
    e.op = '0; e.rs1 = '0; e.rs2 = '0; e.rd = '0; e.imm = '0; e.ctrl = 13'd1;
    if (!legal) return e;
    e.rs1 = (fmt inside {"R", "I", "S", "B"}) ? w[19:15] : 5'd0;
    e.rs2 = (fmt inside {"R", "S", "B"}) ? w[24:20] : 5'd0;
    e.rd  = (fmt inside {"R", "I", "U", "J"}) ? w[11:7] : 5'd0;
    case (fmt)
      "I": e.imm = shift ? {27'd0, w[24:20]} : {{20{w[31]}}, w[31:20]};
      "S": e.imm = {{20{w[31]}}, w[31:25], w[11:7]};
      "B": e.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      "U": e.imm = {w[31:12], 12'd0};
      "J": e.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: e.imm = '0;
    endcase
    e.op = {(opc == 7'h33 || shift) ? f7[5:0] : 6'd0, (fmt inside {"U", "J"}) ? 3'd0 : f3, opc};
    isel  = opc inside {7'h03, 7'h13, 7'h17, 7'h37, 7'h23, 7'h67, 7'h6F};
    alu   = opc inside {7'h13, 7'h33};
    regw  = opc inside {7'h03, 7'h13, 7'h17, 7'h37, 7'h33, 7'h67, 7'h6F};
    dw    = (opc == 7'h23);
    dr    = (opc == 7'h03);
    uns   = (opc == 7'h03 && f3[2]) || (opc == 7'h63 && f3[1]) || (alu && f3 == 3'd3);
    br    = (opc == 7'h63);
    lpc   = opc inside {7'h67, 7'h6F};
    rdsel = dr ? 2'd1 : (opc == 7'h37) ? 2'd2 : lpc ? 2'd3 : 2'd0;
    size  = (dr || dw) ? f3[1:0] : 2'd0;
    e.ctrl = {isel, alu, regw, dw, dr, uns, br, lpc, rdsel, size, 1'b0};
    return e;
  endfunction

  task automatic check_outputs();
    check_eq("out_valid", 32'(out_valid), 32'(m_full));
    check_eq("pause_busy", 32'(pause_busy), 32'(m_pause > 0));
    if (m_full) begin
      check_eq("out_pc", out_pc, m_pc);
      check_eq("op_code", 32'(out_op_code), 32'(m_bund.op));
      check_eq("rs1", 32'(out_rs1_sel), 32'(m_bund.rs1));
      check_eq("rs2", 32'(out_rs2_sel), 32'(m_bund.rs2));
      check_eq("rd", 32'(out_rd_sel), 32'(m_bund.rd));
      check_eq("imm", out_imm, m_bund.imm);
      check_eq("ctrl", 32'({out_imm_rs2_sel, out_alu_sel, out_reg_w, out_data_w, out_data_r,
                            out_unsigned, out_branch, out_load_pc, out_rd_data_sel,
                            out_data_size, out_illegal}), 32'(m_bund.ctrl));
    end
  endtask

  // One clock: check registered outputs, drive inputs, check in_ready, advance the model.
  task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                      input bit ordy, input bit fl);
    bit exp_rdy;
    @(negedge clk);
    check_outputs();
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
    #1;
    exp_rdy = !fl && (m_pause == 0) && (!m_full || ordy);
    check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (m_full && ordy) begin
      emit_pc.push_back(out_pc);
      emit_cyc.push_back(cyc);
    end
    if (fl) begin
      m_full = 0; m_pause = 0;
    end else if (v && exp_rdy) begin
      if (ins == PAUSE) begin
        m_full = 0; m_pause = PCYC;
      end else begin
        m_full = 1; m_bund = ref_decode(ins); m_pc = pc;
      end
    end else if (m_full && ordy) begin
      m_full = 0;
    end else if (m_pause > 0) begin
      m_pause--;
    end
    @(posedge clk);
    cyc++;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int          k;
    w = $urandom;
    k = $urandom_range(0, 19);
    if (k == 0) return PAUSE;
    if (k < 4) return w;
    case ($urandom_range(0, 9))
      0: w[6:0] = 7'h03; 1: w[6:0] = 7'h13; 2: w[6:0] = 7'h17; 3: w[6:0] = 7'h23;
      4: w[6:0] = 7'h33; 5: w[6:0] = 7'h37; 6: w[6:0] = 7'h63; 7: w[6:0] = 7'h67;
      8: w[6:0] = 7'h6F; default: w[6:0] = 7'h0F;
    endcase
    if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    return w;
  endfunction

  initial begin
    int n;
    m_full = 0; m_pause = 0;
    m_bund = ref_decode(32'h0);

    // Reset values
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_pause_busy", 32'(pause_busy), 32'd0);
    check_eq("rst_op_code", 32'(out_op_code), 32'd0);
    check_eq("rst_imm", out_imm, 32'd0);
    check_eq("rst_pc", out_pc, 32'd0);
    check_eq("rst_ctrl", 32'({out_reg_w, out_illegal, out_rd_sel, out_rs1_sel}), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);

    // ADDI, then LW held for 3 cycles of back-pressure
    step(1, 32'h00500093, 32'h100, 1, 0);
    step(1, 32'h0040A103, 32'h104, 1, 0);
    step(1, 32'h00500093, 32'h108, 0, 0);
    step(1, 32'h00500093, 32'h108, 0, 0);
    step(1, 32'h00500093, 32'h108, 0, 0);
    step(0, 32'h0, 32'h0, 1, 0);
    step(0, 32'h0, 32'h0, 1, 0);

    // PAUSE: count busy cycles while ADDI is offered
    step(1, PAUSE, 32'h10C, 1, 0);
    n = 0;
    for (int i = 0; i < PCYC + 2; i++) begin
      if (pause_busy) n++;
      step(1, 32'h00500093, 32'h110, 1, 0);
    end
    check_eq("pause_len", 32'(n), 32'(PCYC));
    step(0, 32'h0, 32'h0, 1, 0);

    // Illegal encodings
    step(1, 32'h00000000, 32'h200, 1, 0);
    step(1, 32'h000010E7, 32'h204, 1, 0);
    step(0, 32'h0, 32'h0, 1, 0);

    // Flush in second pause cycle, and flush of a stalled full bundle
    step(1, PAUSE, 32'h300, 1, 0);
    step(0, 32'h0, 32'h0, 1, 0);
    step(1, 32'h00500093, 32'h304, 1, 1);
    step(0, 32'h0, 32'h0, 1, 0);
    step(1, 32'h0040A103, 32'h308, 0, 0);
    step(0, 32'h0, 32'h0, 0, 0);
    step(1, 32'h00500093, 32'h30C, 0, 1);
    step(0, 32'h0, 32'h0, 1, 0);

    // Back-to-back stream of 8
    emit_pc.delete();
    emit_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      logic [31:0] w;
      w = rand_instr();
      if (w == PAUSE) w = 32'h00500093;
      step(1, w, 32'h400 + 32'(4 * i), 1, 0);
    end
    step(0, 32'h0, 32'h0, 1, 0);
    step(0, 32'h0, 32'h0, 1, 0);
    check_eq("stream_count", 32'(emit_pc.size()), 32'd8);
    for (int i = 0; i < emit_pc.size() && i < 8; i++) begin
      check_eq("stream_pc", emit_pc[i], 32'h400 + 32'(4 * i));
      if (i > 0) check_eq("stream_gap", 32'(emit_cyc[i] - emit_cyc[i-1]), 32'd1);
    end

    // Async reset in the middle of a pause
    step(1, PAUSE, 32'h500, 1, 0);
    step(0, 32'h0, 32'h0, 1, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("arst_out_valid", 32'(out_valid), 32'd0);
    check_eq("arst_pause_busy", 32'(pause_busy), 32'd0);
    check_eq("arst_op_code", 32'(out_op_code), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_full = 0; m_pause = 0;

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom,
           $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
    end
    step(0, 32'h0, 32'h0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
